// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I controller: sequences each instruction over several cycles and
// decodes per-state enables and mux selects, with an optional memory-ready stall.
module multicycle_control_unit #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit BNE_EN        = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic       func7_5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_SLL = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_JAL,
        S_BRANCH
    } state_t;

    state_t state;
    logic   ready;
    logic   branch_legal;
    logic [2:0] alu_func;

    assign ready        = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign branch_legal = (func3 == 3'b000) || (BNE_EN && (func3 == 3'b001));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:    if (ready) state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_R:         state <= S_EXECR;
                        OP_I:         state <= S_EXECI;
                        OP_JAL:       state <= S_JAL;
                        OP_BR:        state <= branch_legal ? S_BRANCH : S_FETCH;
                        default:      state <= S_FETCH;
                    endcase
                end
                S_MEMADR:   state <= opcode[5] ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (ready) state <= S_MEMWB;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: if (ready) state <= S_FETCH;
                S_EXECR:    state <= S_ALUWB;
                S_EXECI:    state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_JAL:      state <= S_ALUWB;
                S_BRANCH:   state <= S_FETCH;
                default:    state <= S_FETCH;
            endcase
        end
    end

    // func7_5 is only consulted for add/sub on R-type, so an X there elsewhere stays contained
    always_comb begin
        case (func3)
            3'b000:  alu_func = (opcode[5] && func7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_func = ALU_SLL;
            3'b010:  alu_func = ALU_SLT;
            3'b100:  alu_func = ALU_XOR;
            3'b101:  alu_func = ALU_SRL;
            3'b110:  alu_func = ALU_OR;
            3'b111:  alu_func = ALU_AND;
            default: alu_func = ALU_ADD;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_SW:   ImmSrc = 2'b01;
            OP_BR:   ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = ready;
                PCWrite   = ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (opcode)
                    OP_LW, OP_SW, OP_R, OP_I, OP_JAL: illegal = 1'b0;
                    OP_BR:   illegal = !branch_legal;
                    default: illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_func;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_func;
            end
            S_ALUWB: RegWrite = 1'b1;
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                PCWrite    = zero ^ func3[0];
            end
            default: ;
        endcase
        // Reset kills every write strobe at once, even one held by a memory stall
        if (!rst_n) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: each instruction is expanded into a
// per-cycle phase script and the expected control word is derived from that script.
module tb_multicycle_control_unit;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_src;
        logic [2:0] alu_control;
        logic       illegal;
    } ctrl_t;

    typedef enum {PH_FETCH, PH_DECODE, PH_ADDR, PH_READ, PH_LOADWB, PH_WRITE,
                  PH_EXECR, PH_EXECI, PH_ALUWB, PH_JAL, PH_BRANCH} phase_t;
    typedef enum {C_LW, C_SW, C_R, C_I, C_BR, C_JAL, C_ILL} iclass_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, func7_5, zero, mem_ready;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    logic       rst_n_b, func7_5_b, zero_b, mem_ready_b;
    logic [6:0] opcode_b;
    logic [2:0] func3_b;
    logic       PCWrite_b, AdrSrc_b, MemWrite_b, IRWrite_b, RegWrite_b, illegal_b;
    logic [1:0] ResultSrc_b, ALUSrcA_b, ALUSrcB_b, ImmSrc_b;
    logic [2:0] ALUControl_b;

    int     tests_run    = 0;
    int     tests_failed = 0;
    bit     check_en     = 1'b0;
    ctrl_t  exp_vec;
    phase_t exp_phase;
    ctrl_t  trace[$];

    multicycle_control_unit dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3), .func7_5(func7_5),
        .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .illegal(illegal)
    );

    multicycle_control_unit #(.MEM_HANDSHAKE(1'b0), .BNE_EN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .opcode(opcode_b), .func3(func3_b), .func7_5(func7_5_b),
        .zero(zero_b), .mem_ready(mem_ready_b), .PCWrite(PCWrite_b), .AdrSrc(AdrSrc_b),
        .MemWrite(MemWrite_b), .IRWrite(IRWrite_b), .RegWrite(RegWrite_b),
        .ResultSrc(ResultSrc_b), .ALUSrcA(ALUSrcA_b), .ALUSrcB(ALUSrcB_b), .ImmSrc(ImmSrc_b),
        .ALUControl(ALUControl_b), .illegal(illegal_b)
    );

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0b, expected %0b (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic ctrl_t dut_vec();
        ctrl_t v;
        v.pc_write    = PCWrite;
        v.adr_src     = AdrSrc;
        v.mem_write   = MemWrite;
        v.ir_write    = IRWrite;
        v.reg_write   = RegWrite;
        v.result_src  = ResultSrc;
        v.alu_src_a   = ALUSrcA;
        v.alu_src_b   = ALUSrcB;
        v.imm_src     = ImmSrc;
        v.alu_control = ALUControl;
        v.illegal     = illegal;
        return v;
    endfunction

    function automatic iclass_t classify(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            OP_LW:   return C_LW;
            OP_SW:   return C_SW;
            OP_R:    return C_R;
            OP_I:    return C_I;
            OP_JAL:  return C_JAL;
            OP_BR:   return (f3 == 3'b000 || f3 == 3'b001) ? C_BR : C_ILL;
            default: return C_ILL;
        endcase
    endfunction

    function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_ok);
        logic [2:0] tbl [0:7];
        tbl = '{3'b000, 3'b111, 3'b101, 3'b000, 3'b100, 3'b110, 3'b011, 3'b010};
        if (f3 == 3'b000 && sub_ok) return 3'b001;
        return tbl[f3];
    endfunction

    // Expected control word for one cycle of a phase, straight from the control table
    function automatic ctrl_t exp_ctrl(input phase_t ph, input logic [6:0] op,
                                       input logic [2:0] f3, input logic f75,
                                       input logic z, input logic rdy);
        ctrl_t e = '0;
        case (op)
            OP_SW:   e.imm_src = 2'b01;
            OP_BR:   e.imm_src = 2'b10;
            OP_JAL:  e.imm_src = 2'b11;
            default: e.imm_src = 2'b00;
        endcase
        case (ph)
            PH_FETCH:  begin e.alu_src_b = 2'b10; e.result_src = 2'b10;
                             e.ir_write = rdy; e.pc_write = rdy; end
            PH_DECODE: begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b01;
                             e.illegal = (classify(op, f3) == C_ILL); end
            PH_ADDR:   begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; end
            PH_READ:   e.adr_src = 1'b1;
            PH_LOADWB: begin e.result_src = 2'b01; e.reg_write = 1'b1; end
            PH_WRITE:  begin e.adr_src = 1'b1; e.mem_write = 1'b1; end
            PH_EXECR:  begin e.alu_src_a = 2'b10; e.alu_control = alu_decode(f3, f75 && op[5]); end
            PH_EXECI:  begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01;
                             e.alu_control = alu_decode(f3, f75 && op[5]); end
            PH_ALUWB:  e.reg_write = 1'b1;
            PH_JAL:    begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1'b1; end
            PH_BRANCH: begin e.alu_src_a = 2'b10; e.alu_control = 3'b001; e.pc_write = z ^ f3[0]; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic [7:0] field_mask(input int sel);
        logic [7:0] m = '0;
        for (int i = 0; i < trace.size() && i < 8; i++) begin
            case (sel)
                0:       m[i] = trace[i].pc_write;
                1:       m[i] = trace[i].mem_write;
                2:       m[i] = trace[i].reg_write;
                default: m[i] = trace[i].ir_write;
            endcase
        end
        return m;
    endfunction

    always @(negedge clk) begin
        if (check_en)
            check_output($sformatf("ctrl_%s", exp_phase.name()), 32'(dut_vec()), 32'(exp_vec));
    end

    // Runs one whole instruction starting in the cycle just after a rising edge.
    // zero_sel: 0/1 fixed zero flag, 2 random. mem_stalls: not-ready cycles in READ/WRITE.
    task automatic apply_stimulus(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                                  input int mem_stalls, input int zero_sel, input bit rand_rdy);
        phase_t script[$];
        int     waited;
        bit     done, wait_ph;
        script = {PH_FETCH, PH_DECODE};
        case (classify(op, f3))
            C_LW:    begin script.push_back(PH_ADDR); script.push_back(PH_READ); script.push_back(PH_LOADWB); end
            C_SW:    begin script.push_back(PH_ADDR); script.push_back(PH_WRITE); end
            C_R:     begin script.push_back(PH_EXECR); script.push_back(PH_ALUWB); end
            C_I:     begin script.push_back(PH_EXECI); script.push_back(PH_ALUWB); end
            C_JAL:   begin script.push_back(PH_JAL); script.push_back(PH_ALUWB); end
            C_BR:    script.push_back(PH_BRANCH);
            default: ;
        endcase
        trace.delete();
        opcode  = op;
        func3   = f3;
        func7_5 = f75;
        foreach (script[i]) begin
            waited = 0;
            done   = 1'b0;
            while (!done) begin
                wait_ph = script[i] inside {PH_FETCH, PH_READ, PH_WRITE};
                if (rand_rdy)
                    mem_ready = (waited >= 6) ? 1'b1 : ($urandom_range(3) != 0);
                else
                    mem_ready = !(wait_ph && script[i] != PH_FETCH && waited < mem_stalls);
                zero      = (zero_sel == 2) ? 1'($urandom_range(1)) : 1'(zero_sel);
                exp_phase = script[i];
                exp_vec   = exp_ctrl(script[i], op, f3, f75, zero, mem_ready);
                check_en  = 1'b1;
                @(negedge clk);
                trace.push_back(dut_vec());
                @(posedge clk);
                #1;
                done = !wait_ph || mem_ready;
                waited++;
            end
        end
        check_en = 1'b0;
    endtask

    initial begin
        logic [2:0] alu_f3 [0:6];
        logic [6:0] op;
        logic [2:0] f3;
        alu_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111};

        rst_n = 1'b0; opcode = OP_LW; func3 = 3'b000; func7_5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
        rst_n_b = 1'b0; opcode_b = OP_BR; func3_b = 3'b001; func7_5_b = 1'b0; zero_b = 1'b0;
        mem_ready_b = 1'b0;

        #12;
        check_output("rst_irwrite", 32'(IRWrite), 32'd0);
        check_output("rst_pcwrite", 32'(PCWrite), 32'd0);
        check_output("rst_alusrcb", 32'(ALUSrcB), 32'b10);
        check_output("rst_resultsrc", 32'(ResultSrc), 32'b10);
        check_output("rst_illegal", 32'(illegal), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_output("first_fetch_irwrite", 32'(IRWrite), 32'd1);

        apply_stimulus(OP_LW, 3'b010, 1'b0, 0, 0, 1'b0);
        check_output("lw_cycles", 32'(trace.size()), 32'd5);
        check_output("lw_regwrite_mask", 32'(field_mask(2)), 32'b10000);
        check_output("lw_resultsrc_wb", 32'(trace[4].result_src), 32'b01);
        check_output("lw_immsrc", 32'(trace[0].imm_src | trace[2].imm_src | trace[4].imm_src), 32'd0);

        apply_stimulus(OP_SW, 3'b010, 1'b0, 2, 0, 1'b0);
        check_output("sw_stall_cycles", 32'(trace.size()), 32'd6);
        check_output("sw_memwrite_mask", 32'(field_mask(1)), 32'b111000);

        apply_stimulus(OP_BR, 3'b000, 1'b0, 0, 0, 1'b0);
        check_output("beq_z0_cycles", 32'(trace.size()), 32'd3);
        check_output("beq_z0_pcwrite", 32'(trace[2].pc_write), 32'd0);
        check_output("beq_alu", 32'(trace[2].alu_control), 32'b001);
        apply_stimulus(OP_BR, 3'b000, 1'b0, 0, 1, 1'b0);
        check_output("beq_z1_pcwrite", 32'(trace[2].pc_write), 32'd1);
        apply_stimulus(OP_BR, 3'b001, 1'b0, 0, 0, 1'b0);
        check_output("bne_z0_pcwrite", 32'(trace[2].pc_write), 32'd1);
        check_output("bne_alu", 32'(trace[2].alu_control), 32'b001);

        apply_stimulus(OP_R, 3'b000, 1'b1, 0, 0, 1'b0);
        check_output("r_sub", 32'(trace[2].alu_control), 32'b001);
        apply_stimulus(OP_R, 3'b101, 1'($urandom_range(1)), 0, 0, 1'b0);
        check_output("r_srl", 32'(trace[2].alu_control), 32'b110);
        apply_stimulus(OP_R, 3'b100, 1'($urandom_range(1)), 0, 0, 1'b0);
        check_output("r_xor", 32'(trace[2].alu_control), 32'b100);
        apply_stimulus(OP_I, 3'b000, 1'b1, 0, 0, 1'b0);
        check_output("addi_no_sub", 32'(trace[2].alu_control), 32'b000);
        check_output("r_cycles", 32'(trace.size()), 32'd4);

        apply_stimulus(OP_JAL, 3'b000, 1'b0, 0, 0, 1'b0);
        check_output("jal_cycles", 32'(trace.size()), 32'd4);
        check_output("jal_pcwrite_mask", 32'(field_mask(0)), 32'b0101);
        check_output("jal_resultsrc", 32'(trace[2].result_src), 32'b00);
        check_output("jal_regwrite_mask", 32'(field_mask(2)), 32'b1000);
        check_output("jal_immsrc", 32'(trace[1].imm_src), 32'b11);

        // Abort a store held in a memory stall with an asynchronous reset
        opcode = OP_SW; func3 = 3'b010; mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        mem_ready = 1'b0;
        #2;
        check_output("stall_memwrite", 32'(MemWrite), 32'd1);
        @(posedge clk);
        #3;
        check_output("stall_memwrite_held", 32'(MemWrite), 32'd1);
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        check_output("abort_memwrite", 32'(MemWrite), 32'd0);
        check_output("abort_enables", 32'({PCWrite, IRWrite, RegWrite, illegal}), 32'd0);
        check_output("abort_fetch_sel", 32'({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}), 32'b0_00_10_10);
        @(posedge clk);
        #1;
        check_output("abort_after_edge", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
        mem_ready = 1'b0;
        rst_n = 1'b1;

        // Second instance: no handshake and no bne, while the first idles in a fetch stall
        rst_n_b = 1'b1;
        #2;
        check_output("nohs_fetch_irwrite", 32'(IRWrite_b), 32'd1);
        @(posedge clk); #2;
        check_output("bne_disabled_illegal", 32'(illegal_b), 32'd1);
        check_output("bne_disabled_pcwrite", 32'(PCWrite_b), 32'd0);
        @(posedge clk); #2;
        check_output("illegal_back_fetch", 32'({illegal_b, IRWrite_b}), 32'b01);
        func3_b = 3'b000; zero_b = 1'b1;
        @(posedge clk); #2;
        check_output("beq_legal_b", 32'(illegal_b), 32'd0);
        @(posedge clk); #2;
        check_output("beq_b_branch", 32'({PCWrite_b, ALUControl_b}), 32'b1_001);
        check_output("fetch_stall_idle", 32'({PCWrite, IRWrite}), 32'd0);
        rst_n_b = 1'b0;
        @(posedge clk);
        #1;

        for (int n = 0; n < 300; n++) begin
            f3 = alu_f3[$urandom_range(6)];
            case ($urandom_range(6))
                0: op = OP_LW;
                1: op = OP_SW;
                2: op = OP_R;
                3: op = OP_I;
                4: begin op = OP_BR; f3 = ($urandom_range(4) == 0) ? f3 : 3'($urandom_range(1)); end
                5: op = OP_JAL;
                default: begin
                    op = 7'($urandom_range(127));
                    if (classify(op, 3'b000) != C_ILL) op = 7'b1111111;
                end
            endcase
            apply_stimulus(op, f3, 1'($urandom_range(1)), 0, 2, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
